// File: rtl/background_pixel_writer.sv
// ============================================================================
// background_pixel_writer
//   Packs a raster-order stream of palette indices 8 per word (leftmost pixel in
//   the top byte) and writes the words sequentially into the background RAM.
//   Optional BG_WRITER_CLEAR_EN adds a clear mode that fills the whole frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module background_pixel_writer #(
    parameter int IMG_W        = 320,
    parameter int IMG_H        = 240,
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 8,
    parameter int ADDR_W       = 14
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [PIX_W-1:0]              pix_data,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [PIX_W*PIX_PER_WORD-1:0] wr_data,
    input  logic                          wr_ready,
    output logic                          busy,
    output logic                          done
`ifdef BG_WRITER_CLEAR_EN
    ,
    input  logic                          clear_req,
    input  logic [PIX_W-1:0]              clear_index
`endif
);

    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int WORDS  = IMG_W * IMG_H / PIX_PER_WORD;
    localparam int SLOT_W = $clog2(PIX_PER_WORD);
    localparam int FILL_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    localparam logic [FILL_W-1:0] ALL_WORDS = FILL_W'(WORDS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PIX_PER_WORD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2
`ifdef BG_WRITER_CLEAR_EN
        ,
        S_CLEAR = 2'd3
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                acc_full_q, acc_full_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
`ifdef BG_WRITER_CLEAR_EN
    logic [PIX_W-1:0]    clr_q, clr_d;
`endif

    logic              w_wr_acc;
    logic              w_out_free;
    logic              w_pix_ready;
    logic              w_pix_acc;
    logic              w_last_pix;
    logic [WORD_W-1:0] w_word;

    // The output register can take a new word if empty or emptying this cycle.
    assign w_wr_acc    = out_valid_q && wr_ready;
    assign w_out_free  = !out_valid_q || wr_ready;
    assign w_pix_ready = (state_q == S_LOAD) && (fill_q != ALL_WORDS)
                         && !(acc_full_q && !w_out_free);
    assign w_pix_acc   = pix_valid && w_pix_ready;
    assign w_last_pix  = w_pix_acc && (slot_q == LAST_SLOT);
    assign w_word      = {acc_q[WORD_W-PIX_W-1:0], pix_data};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        slot_d      = slot_q;
        acc_full_d  = acc_full_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        addr_d      = addr_q;
        fill_d      = fill_q;
`ifdef BG_WRITER_CLEAR_EN
        clr_d       = clr_q;
`endif

        if (w_wr_acc) begin
            out_valid_d = 1'b0;
            addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        end

        if (acc_full_q && w_out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
            acc_full_d  = 1'b0;
        end

        if (w_pix_acc) begin
            acc_d  = w_word;
            slot_d = w_last_pix ? '0 : slot_q + SLOT_W'(1);
            if (w_last_pix) begin
                fill_d = fill_q + FILL_W'(1);
                // A completed word bypasses the accumulator when the skid is free.
                if (w_out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = w_word;
                end else begin
                    acc_full_d  = 1'b1;
                end
            end
        end

`ifdef BG_WRITER_CLEAR_EN
        if ((state_q == S_CLEAR) && w_out_free && (fill_q != ALL_WORDS)) begin
            out_valid_d = 1'b1;
            out_data_d  = {PIX_PER_WORD{clr_q}};
            fill_d      = fill_q + FILL_W'(1);
        end
`endif

        unique case (state_q)
            S_IDLE: begin
`ifdef BG_WRITER_CLEAR_EN
                if (clear_req) begin
                    state_d = S_CLEAR;
                    clr_d   = clear_index;
                    fill_d  = '0;
                end else
`endif
                if (start) begin
                    state_d = S_LOAD;
                    fill_d  = '0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (w_wr_acc && (addr_q == LAST_ADDR)) state_d = S_DONE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            slot_q      <= '0;
            acc_full_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            addr_q      <= '0;
            fill_q      <= '0;
`ifdef BG_WRITER_CLEAR_EN
            clr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            slot_q      <= slot_d;
            acc_full_q  <= acc_full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            addr_q      <= addr_d;
            fill_q      <= fill_d;
`ifdef BG_WRITER_CLEAR_EN
            clr_q       <= clr_d;
`endif
        end
    end

    assign pix_ready = w_pix_ready;
    assign wr_en     = out_valid_q;
    assign wr_addr   = addr_q;
    assign wr_data   = out_data_q;
    assign done      = (state_q == S_DONE);
`ifdef BG_WRITER_CLEAR_EN
    assign busy      = (state_q == S_LOAD) || (state_q == S_CLEAR);
`else
    assign busy      = (state_q == S_LOAD);
`endif

endmodule

`default_nettype wire

// File: tb/tb_background_pixel_writer.sv
// ============================================================================
// tb_background_pixel_writer
//   Directed vector table plus hand sequences for stall, partial word, abort,
//   full frame and (optionally) clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_background_pixel_writer;

    localparam int WORDS = 9600;
    localparam int FRAME = 76800;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [63:0] wr_data;
    logic        wr_ready = 1'b0;
    logic        busy;
    logic        done;
`ifdef BG_WRITER_CLEAR_EN
    logic        clear_req = 1'b0;
    logic [7:0]  clear_index = 8'h00;
`endif

    background_pixel_writer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done)
`ifdef BG_WRITER_CLEAR_EN
        ,
        .clear_req  (clear_req),
        .clear_index(clear_index)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        wr;
        logic        pr;
        logic        wen;
        logic [13:0] addr;
        logic [63:0] data;
        logic        bsy;
        logic        dn;
    } vec_t;

    vec_t        tv [23];
    int          n_vec = 0;
    int          n_err = 0;
    int          mp = 0;
    int          n_wr = 0;
    int          mp0;
    int          guard;
    logic [63:0] mw = 64'd0;
    logic [13:0] exp_addr = 14'd0;
    logic [63:0] exp_q [$];
    bit          clr_mode = 1'b0;
    bit          v_rand;

    task automatic model_reset();
        mp = 0;
        n_wr = 0;
        mw = 64'd0;
        exp_addr = 14'd0;
        exp_q.delete();
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Drive inputs, then at the falling edge score writes and track accepted pixels.
    task automatic half(input logic s, input logic v, input logic [7:0] d, input logic wr);
        logic [63:0] ew;
        start = s;
        pix_valid = v;
        pix_data = d;
        wr_ready = wr;
        @(negedge clock);
        if (wr_en && wr_ready) begin
            if (!clr_mode && exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_spurious: got addr=%0d data=%h, want no write", wr_addr, wr_data);
            end else begin
                ew = clr_mode ? 64'h2A2A2A2A2A2A2A2A : exp_q.pop_front();
                check("wr_word", {wr_addr, wr_data}, {exp_addr, ew});
            end
            n_wr++;
            exp_addr = (exp_addr == 14'(WORDS - 1)) ? 14'd0 : exp_addr + 14'd1;
        end
        if (pix_valid && pix_ready) begin
            mw = {mw[55:0], pix_data};
            mp++;
            if (mp % 8 == 0) exp_q.push_back(mw);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d, input logic wr);
        half(s, v, d, wr);
        tick();
    endtask

    initial begin
        tv[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 14'd0, 64'd0, 1'b0, 1'b0};
        for (int i = 1; i <= 8; i++)
            tv[i] = '{1'b0, 1'b1, 8'(i - 1), 1'b1, 1'b1, 1'b0, 14'd0, 64'd0, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 14'd0, 64'h0001020304050607, 1'b1, 1'b0};
        tv[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 14'd0, 64'h0001020304050607, 1'b1, 1'b0};
        tv[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 14'd0, 64'h0001020304050607, 1'b1, 1'b0};
        tv[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 14'd0, 64'd0, 1'b1, 1'b0};
        for (int i = 13; i <= 20; i++)
            tv[i] = '{1'b0, 1'b1, 8'(i - 5), 1'b1, 1'b1, 1'b0, 14'd0, 64'd0, 1'b1, 1'b0};
        tv[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 14'd1, 64'h08090A0B0C0D0E0F, 1'b1, 1'b0};
        tv[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 14'd0, 64'd0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_ctrl", {pix_ready, wr_en, busy, done}, 4'b0000);
        check("rst_addr", wr_addr, 14'd0);
        check("rst_data", wr_data, 64'd0);
        reset_n = 1'b1;
        tick();

        // Single words, latency and short stall from the vector table
        for (int i = 0; i < 23; i++) begin
            half(tv[i].st, tv[i].v, tv[i].d, tv[i].wr);
            n_vec++;
            if (pix_ready !== tv[i].pr || wr_en !== tv[i].wen || busy !== tv[i].bsy ||
                done !== tv[i].dn || (tv[i].wen && (wr_addr !== tv[i].addr || wr_data !== tv[i].data))) begin
                n_err++;
                $display("FAIL vec%0d: got pr=%b wen=%b addr=%0d data=%h busy=%b done=%b, want pr=%b wen=%b addr=%0d data=%h busy=%b done=%b",
                         i, pix_ready, wr_en, wr_addr, wr_data, busy, done,
                         tv[i].pr, tv[i].wen, tv[i].addr, tv[i].data, tv[i].bsy, tv[i].dn);
            end
            tick();
        end

        // Long stall with a continuous stream
        guard = 0;
        while (!wr_en && guard < 20) begin
            cyc(1'b0, 1'b1, 8'(mp), 1'b0);
            guard++;
        end
        check("stall_first", {wr_en, wr_addr, wr_data}, {1'b1, 14'd2, 64'h1011121314151617});
        mp0 = mp;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 8'(mp), 1'b0);
            check("stall_hold", {wr_en, wr_addr, wr_data}, {1'b1, 14'd2, 64'h1011121314151617});
        end
        check("stall_fill", mp - mp0, 8);
        check("stall_pready", pix_ready, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 8'(mp), 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("stall_words", n_wr, 9);

        // 77 pixels: partial word must stay in the accumulator
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        guard = 0;
        while (mp < 77 && guard < 200) begin
            cyc(1'b0, 1'b1, 8'(mp), 1'b1);
            guard++;
        end
        repeat (10) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("part_words", n_wr, 9);
        check("part_wen", wr_en, 1'b0);
        while (mp < 80 && guard < 300) begin
            cyc(1'b0, 1'b1, 8'(mp), 1'b1);
            guard++;
        end
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("part_complete", n_wr, 10);

        // Start during LOAD is ignored; asynchronous abort after word 100
        cyc(1'b1, 1'b1, 8'(mp), 1'b1);
        check("start_ignored", {busy, done}, 2'b10);
        guard = 0;
        while (n_wr < 101 && guard < 2000) begin
            cyc(1'b0, 1'b1, 8'(mp), 1'b1);
            guard++;
        end
        check("abort_words", n_wr, 101);
        reset_n = 1'b0;
        #2;
        check("abort_ctrl", {pix_ready, wr_en, busy, done}, 4'b0000);
        check("abort_addr", wr_addr, 14'd0);
        check("abort_data", wr_data, 64'd0);
        tick();
        reset_n = 1'b1;
        model_reset();

        // Full frame with occasional pix_valid gaps
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        check("frame_busy", {busy, done}, 2'b10);
        guard = 0;
        while (n_wr < WORDS && guard < 90000) begin
            v_rand = (mp >= FRAME) ? 1'b1 : ($urandom_range(0, 31) != 0);
            cyc(1'b0, v_rand, 8'(mp), 1'b1);
            if (mp == FRAME && n_wr < WORDS) check("frame_tail_pready", pix_ready, 1'b0);
            guard++;
        end
        check("frame_words", n_wr, WORDS);
        check("frame_done", {done, busy, pix_ready}, 3'b100);
        check("frame_addr_wrap", wr_addr, 14'd0);
        cyc(1'b0, 1'b1, 8'(mp), 1'b1);
        check("frame_idle", {done, busy, wr_en}, 3'b000);
        check("frame_pixels", mp, FRAME);

`ifdef BG_WRITER_CLEAR_EN
        // Clear mode wins over a simultaneous start
        model_reset();
        clr_mode = 1'b1;
        clear_index = 8'h2A;
        clear_req = 1'b1;
        half(1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        clear_req = 1'b0;
        clear_index = 8'h55;
        check("clear_busy", {busy, done}, 2'b10);
        guard = 0;
        while (n_wr < WORDS && guard < 12000) begin
            cyc(1'b0, 1'b1, 8'h11, 1'b1);
            guard++;
        end
        check("clear_words", n_wr, WORDS);
        check("clear_done", {done, busy}, 2'b10);
        check("clear_no_pixels", mp, 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("clear_idle", {done, busy, wr_en}, 3'b000);
        clr_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
